// File: rtl/countdown_entry_pkg.sv
// Shared types and constants for the countdown digit-entry controller.
// Key events are encoded as small integers so one priority pick can carry them.
package countdown_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [3:0] MAX_SEC_TENS = 4'd5;

    typedef enum logic [1:0] {
        IDLE,
        EDIT,
        ARMED,
        RUN
    } state_e;

    typedef logic [2:0] key_t;

    localparam key_t KEY_NONE    = 3'd0;
    localparam key_t KEY_CLEAR   = 3'd1;
    localparam key_t KEY_CONFIRM = 3'd2;
    localparam key_t KEY_START   = 3'd3;
    localparam key_t KEY_NUM     = 3'd4;

    function automatic logic is_digit(input logic [3:0] v);
        return v <= 4'd9;
    endfunction

endpackage

// File: rtl/countdown_entry_if.sv
// Keypad/timer side bundle of the countdown entry controller.
// master drives keys and busy; slave is the controller.
interface countdown_entry_if #(
    parameter int NUM_DIGITS = 4
);

    logic                    keydown_start;
    logic                    keydown_confirm;
    logic                    keydown_clear;
    logic                    keydown_num;
    logic [3:0]              num;
    logic                    busy;
    logic [4*NUM_DIGITS-1:0] digits_out;
    logic [3:0]              entry_count;
    logic [4*NUM_DIGITS-1:0] preset;
    logic                    preset_valid;
    logic                    load;
    logic                    start;
    logic                    stop;
    logic                    error;
    logic                    editing;

    modport master (
        output keydown_start,
        output keydown_confirm,
        output keydown_clear,
        output keydown_num,
        output num,
        output busy,
        input  digits_out,
        input  entry_count,
        input  preset,
        input  preset_valid,
        input  load,
        input  start,
        input  stop,
        input  error,
        input  editing
    );

    modport slave (
        input  keydown_start,
        input  keydown_confirm,
        input  keydown_clear,
        input  keydown_num,
        input  num,
        input  busy,
        output digits_out,
        output entry_count,
        output preset,
        output preset_valid,
        output load,
        output start,
        output stop,
        output error,
        output editing
    );

endinterface

// File: rtl/countdown_entry_key_edge.sv
// Rising-edge key detector with fixed priority, plus busy falling-edge detect.
// Key history resets high so a key held across reset never fires.
module key_edge
    import countdown_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kd_clear,
    input  logic       kd_confirm,
    input  logic       kd_start,
    input  logic       kd_num,
    input  logic [3:0] num_i,
    input  logic       busy_i,
    output key_t       key_ev,
    output logic [3:0] key_num,
    output logic       busy_fall
);

    logic [3:0] keys_d, keys_q;
    logic [3:0] rise;
    logic       busy_d, busy_q;

    assign keys_d = {kd_num, kd_start, kd_confirm, kd_clear};
    assign rise   = keys_d & ~keys_q;
    assign busy_d = busy_i;

    always_comb begin
        key_ev = KEY_NONE;
        priority case (1'b1)
            rise[0]: key_ev = KEY_CLEAR;
            rise[1]: key_ev = KEY_CONFIRM;
            rise[2]: key_ev = KEY_START;
            rise[3]: key_ev = KEY_NUM;
            default: key_ev = KEY_NONE;
        endcase
    end

    assign key_num   = num_i;
    assign busy_fall = busy_q & ~busy_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keys_q <= 4'hF;
            busy_q <= 1'b0;
        end else begin
            keys_q <= keys_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/countdown_entry.sv
// Digit-entry and arming controller: BCD MM:SS buffer, preset latch,
// and load/start/stop/error pulses toward the countdown timer.
module countdown_entry
    import countdown_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    countdown_entry_if.slave   bus
);

    localparam int W = DIGIT_W * NUM_DIGITS;
    localparam logic [3:0] MAX_CNT = 4'(NUM_DIGITS);

    key_t       ev;
    logic [3:0] knum;
    logic       busy_fall;

    key_edge u_key_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .kd_clear   (bus.keydown_clear),
        .kd_confirm (bus.keydown_confirm),
        .kd_start   (bus.keydown_start),
        .kd_num     (bus.keydown_num),
        .num_i      (bus.num),
        .busy_i     (bus.busy),
        .key_ev     (ev),
        .key_num    (knum),
        .busy_fall  (busy_fall)
    );

    state_e       state_d, state_q;
    logic [W-1:0] buf_d, buf_q;
    logic [3:0]   cnt_d, cnt_q;
    logic [W-1:0] preset_d, preset_q;
    logic         pv_d, pv_q;
    logic         load_d, load_q;
    logic         start_d, start_q;
    logic         stop_d, stop_q;
    logic         err_d, err_q;
    logic         edit_d, edit_q;

    logic         digit;
    logic         sec_ok;
    logic [W-1:0] shifted;
    logic [W-1:0] single;

    assign digit   = (ev == KEY_NUM) && is_digit(knum);
    assign sec_ok  = buf_q[7:4] <= MAX_SEC_TENS;
    assign shifted = {buf_q[W-DIGIT_W-1:0], knum};
    assign single  = {{(W-DIGIT_W){1'b0}}, knum};

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        preset_d = preset_q;
        pv_d     = pv_q;
        load_d   = 1'b0;
        start_d  = 1'b0;
        stop_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (digit) begin
                    buf_d   = single;
                    cnt_d   = 4'd1;
                    state_d = EDIT;
                end else if (ev == KEY_CONFIRM || ev == KEY_START) begin
                    err_d = 1'b1;
                end
            end
            EDIT: begin
                if (ev == KEY_CLEAR) begin
                    buf_d   = '0;
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else if (ev == KEY_CONFIRM) begin
                    if (sec_ok) begin
                        preset_d = buf_q;
                        pv_d     = 1'b1;
                        load_d   = 1'b1;
                        state_d  = ARMED;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (ev == KEY_START) begin
                    err_d = 1'b1;
                end else if (digit) begin
                    if (cnt_q < MAX_CNT) begin
                        buf_d = shifted;
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ARMED: begin
                if (ev == KEY_CLEAR) begin
                    buf_d   = '0;
                    cnt_d   = 4'd0;
                    pv_d    = 1'b0;
                    state_d = IDLE;
                end else if (ev == KEY_START) begin
                    start_d = 1'b1;
                    state_d = RUN;
                end else if (digit) begin
                    buf_d   = single;
                    cnt_d   = 4'd1;
                    state_d = EDIT;
                end
            end
            RUN: begin
                if (ev == KEY_CLEAR) begin
                    stop_d  = 1'b1;
                    state_d = ARMED;
                end else begin
                    // Timer finishing and a stray key in the same cycle: do both.
                    if (ev == KEY_CONFIRM || ev == KEY_START || digit) begin
                        err_d = 1'b1;
                    end
                    if (busy_fall) begin
                        state_d = ARMED;
                    end
                end
            end
        endcase
        edit_d = (state_d == EDIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            buf_q    <= '0;
            cnt_q    <= 4'd0;
            preset_q <= '0;
            pv_q     <= 1'b0;
            load_q   <= 1'b0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            err_q    <= 1'b0;
            edit_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            preset_q <= preset_d;
            pv_q     <= pv_d;
            load_q   <= load_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            err_q    <= err_d;
            edit_q   <= edit_d;
        end
    end

    assign bus.digits_out   = buf_q;
    assign bus.entry_count  = cnt_q;
    assign bus.preset       = preset_q;
    assign bus.preset_valid = pv_q;
    assign bus.load         = load_q;
    assign bus.start        = start_q;
    assign bus.stop         = stop_q;
    assign bus.error        = err_q;
    assign bus.editing      = edit_q;

endmodule

// File: doc/countdown_entry.md
# countdown_entry

Digit-entry and arming controller directly downstream of the keypad block. Turns the keypad's level-style `keydown_*` / `num` outputs into one-shot key events and shifts digits into a BCD MM:SS buffer. It validates and latches the preset on confirm, then issues load and start pulses to the countdown timer. It also tracks whether the timer is running, using the timer's `busy` flag.

## Interface
Parameters:
- `NUM_DIGITS`, 4: BCD digits in entry buffer; legal range 2..8.

Ports:
- `clk`  in  1: single clock, same clock as the keypad scan.
- `rst_n`  in  1: asynchronous, active-low reset.
- `keydown_start`  in  1: start key held, level.
- `keydown_confirm`  in  1: confirm key held, level.
- `keydown_clear`  in  1: clear key held, level.
- `keydown_num`  in  1: numeric key held, level.
- `num`  in  4: key value; only valid while `keydown_num` is high.
- `busy`  in  1: countdown timer running, level.
- `digits_out`  out  4*NUM_DIGITS: live entry buffer for the display; nibble 0 holds the most recent digit.
- `entry_count`  out  4: digits entered so far, 0..NUM_DIGITS.
- `preset`  out  4*NUM_DIGITS: last confirmed value.
- `preset_valid`  out  1: `preset` holds a confirmed value.
- `load`  out  1: one-cycle pulse; `preset` was updated.
- `start`  out  1: one-cycle pulse; begin countdown.
- `stop`  out  1: one-cycle pulse; abort countdown.
- `error`  out  1: one-cycle pulse; illegal key action.
- `editing`  out  1: high in state EDIT.

## Operation
- All inputs are synchronous to `clk` and need no synchronizer.
- **Key events.** Each `keydown_*` input is registered once. An event is the current sample high while the previous sample was low. `num` is captured in the same cycle as the `keydown_num` event.
- **Priority.** When several events occur in one cycle, the order is clear > confirm > start > num. Lower-priority events in that cycle are discarded without raising `error`.
- **Digit filter.** A num event with `num` > 9 is ignored and raises no error.
- **Digit shift.** Buffer ← {buffer[4*NUM_DIGITS-5:0], num}; `entry_count` increments.
- **Validation.** Nibble 1 (seconds tens) must be ≤ 5.
- States: IDLE, EDIT, ARMED, RUN.
  - **IDLE** (buffer = 0, `entry_count` = 0):
    - digit → shift, go to EDIT.
    - confirm → `error`.
    - start → `error`.
    - clear → no action.
  - **EDIT**:
    - digit with `entry_count` < NUM_DIGITS → shift.
    - digit with `entry_count` = NUM_DIGITS → `error`; buffer unchanged.
    - clear → zero the buffer and count, go to IDLE.
    - confirm, valid → `preset` ← buffer, set `preset_valid`, pulse `load`, go to ARMED. Entry with fewer digits than NUM_DIGITS is legal.
    - confirm, invalid → `error`, stay in EDIT.
    - start → `error`.
  - **ARMED**:
    - start → pulse `start`, go to RUN.
    - digit → buffer ← {0…, num}, count = 1, go to EDIT. `preset` and `preset_valid` are retained.
    - clear → zero the buffer, clear `preset_valid`, go to IDLE.
    - confirm → no action.
  - **RUN**:
    - A falling edge of `busy` (registered sample 1 → 0) → go to ARMED.
    - clear → pulse `stop`, go to ARMED.
    - confirm, start and digit → `error`.

## Timing
- **Reset values.** All outputs are 0 and the state is IDLE. The previous-sample registers for the keys reset to 1, so a key held through reset does not produce an event after release. The previous-sample register for `busy` resets to 0.
- **Latency.** A key level first sampled high at edge k updates state and all outputs at edge k, so they are visible in cycle k+1. A pulse lasts exactly one cycle.
- **`load` / `preset`.** `load` and the new `preset` value appear in the same cycle.
- **`start` / `busy`.** `busy` may rise any number of cycles after `start`. RUN exits only on a registered falling edge of `busy`. If `busy` is still low, RUN waits for it to rise and then fall.
- **Key held.** A key held for N cycles produces one event. A key must be released for at least one cycle before it can produce another event.
- **Reset mid-operation.** Asynchronous reset returns the block to the reset state immediately. Any pulse in flight is truncated.

## Structure
- **Package `countdown_pkg`:**
  - state enum (IDLE/EDIT/ARMED/RUN);
  - `DIGIT_W` = 4;
  - `MAX_SEC_TENS` = 5;
  - `KEY_NONE`/`KEY_CLEAR`/`KEY_CONFIRM`/`KEY_START`/`KEY_NUM` event-encoding constants.
- **Sub-module `key_edge`:** registers the 4 key levels and `busy` (reset values as above). Outputs the prioritised single event, captured `num`, and the `busy` falling edge.
- **Top module:** FSM, buffer, count and output registers.

## Test plan
- **Normal entry.** Reset, then keys 1,2,3,0 then confirm → `digits_out` = 0x1230, `entry_count` = 4, `load` for 1 cycle, `preset` = 0x1230, `preset_valid` = 1, state ARMED.
- **Invalid seconds.** Keys 1,7,5 then confirm → nibble 1 = 7 > 5 → `error` pulse, no `load`, `editing` stays 1.
- **Overflow.** Five digits 9,8,5,4,3 → the fifth digit raises `error` and the buffer stays at 0x9854. Then clear → buffer 0, `entry_count` 0, IDLE.
- **Run cycle.** From ARMED, press start → `start` pulse. Drive `busy` high for 10 cycles, then low → back in ARMED. Start again → another `start` pulse.
- **Simultaneous keys.** Clear and num=5 rise in the same cycle while in EDIT → clear wins, buffer = 0, no `error`. A key held for 50 cycles → exactly one event.
- **Reset behaviour.** Assert `rst_n` low while in RUN with confirm held → all outputs 0. Release reset with confirm still held → no `error` and no event until confirm is released and pressed again.
